// File: rtl/mul_add_issue_ctrl.sv
// mul_add_issue_ctrl
// Valid/ready front-end for a fixed-latency, non-stallable multiply-add
// pipeline (p = a*b + c). Operands are forwarded combinationally to the
// pipeline. A valid shift register tracks which pipeline slots carry real
// work. Real results are captured into a small output FIFO. Credits
// (queued + in-flight < DEPTH) ensure that a capture never meets a full
// FIFO, even though the pipeline cannot stall.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake
//   in_a, in_b, in_c          operands
//   pipe_a, pipe_b, pipe_c    operands to the pipeline (copy of in_*)
//   pipe_p                    pipeline result, LATENCY edges after sampling
//   out_valid/out_ready       result handshake
//   out_p                     FIFO head result
//   idle                      nothing in flight and FIFO empty
//
// DEPTH must be a power of two, at least 2, and at least LATENCY.
module mul_add_issue_ctrl #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic [WIDTH-1:0] pipe_a,
  output logic [WIDTH-1:0] pipe_b,
  output logic [WIDTH-1:0] pipe_c,
  input  logic [WIDTH-1:0] pipe_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic               issue;
  logic               capture;
  logic               push;
  logic               pop;

  logic [LATENCY-1:0] vld_reg;
  logic [LATENCY-1:0] vld_next;
  logic [PW-1:0]      inflight_reg;
  logic [PW-1:0]      inflight_next;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      rd_ptr_reg;
  logic [PW-1:0]      rd_ptr_next;
  logic [PW-1:0]      wr_ptr_reg;
  logic [PW-1:0]      wr_ptr_next;
  logic [PW-1:0]      count_reg;
  logic [PW-1:0]      count_next;
  logic [PW:0]        occupancy;

  // The pipeline samples every edge; only the handshake decides whether
  // the sample is real work.
  assign pipe_a = in_a;
  assign pipe_b = in_b;
  assign pipe_c = in_c;

  assign issue   = in_valid & in_ready;
  assign capture = vld_reg[LATENCY-1];
  assign push    = capture;
  assign pop     = out_valid & out_ready;

  // Valid shift register: bit gi marks a real operand gi+1 edges old.
  assign vld_next[0] = issue;
  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vld
      assign vld_next[gi] = vld_reg[gi-1];
    end
  endgenerate

  // Counter equal to popcount(vld_reg): +1 on issue, -1 as a result lands.
  assign inflight_next = inflight_reg + PW'(issue) - PW'(capture);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg + PW'(push) - PW'(pop);
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg      <= '0;
      inflight_reg <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      vld_reg      <= vld_next;
      inflight_reg <= inflight_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Storage carries no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= pipe_p;
    end
  end

  // The credit check uses registered state only, so a pop frees a slot
  // one cycle later and out_ready never reaches in_ready combinationally.
  assign occupancy = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign in_ready  = !rst && (occupancy < (PW + 1)'(DEPTH));

  assign out_valid = (count_reg != '0);
  assign out_p     = mem[rd_ptr_reg[AW-1:0]];
  assign idle      = (inflight_reg == '0) && (count_reg == '0);

  // A capture into a full FIFO would lose a result; credits rule it out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count_reg == PW'(DEPTH))));
    end
  end

endmodule

// File: tb/tb_mul_add_issue_ctrl.sv
// Testbench for mul_add_issue_ctrl: includes a 3-stage multiply-add
// pipeline model feeding pipe_p. A scoreboard queue holds expected
// results (a*b+c mod 2^16) and is popped by a negedge monitor.
module tb_mul_add_issue_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0, in_c = '0;
  logic [W-1:0] pipe_a, pipe_b, pipe_c, pipe_p;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_p;
  logic         idle;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_issued = 0;
  int ready_mode = 0;   // 0: out_ready low, 1: high, 2: random
  bit strict_lat = 1'b0;

  typedef struct {
    logic [W-1:0] p;
    int           cyc;
  } item_t;
  item_t exp_q[$];

  always #5 clk = ~clk;

  mul_add_issue_ctrl #(.WIDTH(W), .LATENCY(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
    .pipe_p(pipe_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .idle(idle)
  );

  // External pipeline: three register stages, never stalls.
  logic [W-1:0] s0, s1, s2;
  always @(posedge clk) begin
    s0 <= W'(32'(pipe_a) * 32'(pipe_b) + 32'(pipe_c));
    s1 <= s0;
    s2 <= s1;
  end
  assign pipe_p = s2;

  // Single driver for out_ready.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else                 out_ready = (ready_mode == 1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_madd(input logic [W-1:0] a, b, c);
    longint unsigned r;
    r = (longint'(a) * longint'(b) + longint'(c)) % 65536;
    return W'(r);
  endfunction

  // Monitor: inputs are stable around the negedge, so these samples are
  // exactly what the next rising edge will act on.
  always @(negedge clk) begin
    item_t it;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          chk("out_p_head", int'(out_p), int'(exp_q[0].p));
          if (out_ready) begin
            it = exp_q.pop_front();
            if (strict_lat) chk("latency_exact", cyc - it.cyc, 4);
            else            chk("latency_min", int'(cyc - it.cyc >= 4), 1);
            $display("pop p=0x%04h lat=%0d", out_p, cyc - it.cyc);
          end
        end
      end
      if (in_valid && in_ready) begin
        it.p   = ref_madd(in_a, in_b, in_c);
        it.cyc = cyc;
        exp_q.push_back(it);
        n_issued++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a triple and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] a, b, c);
    bit ok = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  // Wait for the next out_valid and compare the head to a fixed value.
  task automatic wait_out(input string name, input int exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk(name, out_valid ? int'(out_p) : -1, exp);
  endtask

  initial begin
    automatic bit pat [6] = '{1, 0, 1, 1, 0, 1};
    bit seen;
    int base;
    int n;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_in_ready_held", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode = 1;
    strict_lat = 1'b1;
    step(2);

    // Single op
    @(negedge clk);
    chk("single_idle_before", int'(idle), 1);
    @(posedge clk); #1;
    send(16'd3, 16'd4, 16'd5);
    wait_out("single_p", 17);
    @(negedge clk);
    chk("single_one_cycle", int'(out_valid), 0);
    chk("single_idle_after", int'(idle), 1);
    @(posedge clk); #1;

    // Wrap
    send(16'hFFFF, 16'hFFFF, 16'h0002);
    send(16'h0100, 16'h0100, 16'hFFFF);
    wait_out("wrap_1", 'h0003);
    @(negedge clk);
    chk("wrap_2", out_valid ? int'(out_p) : -1, 'hFFFF);
    @(posedge clk); #1;
    step(6);

    // Backpressure
    strict_lat = 1'b0;
    ready_mode = 0;
    step(2);
    base = n_issued;
    for (int i = 0; i < 4; i++) send(W'(10 + i), W'(7), W'(i));
    in_valid = 1'b1;
    in_a = 16'd99; in_b = 16'd2; in_c = 16'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_full_no_ready", int'(in_ready), 0);
    end
    chk("bp_accepted_4", n_issued - base, 4);
    @(posedge clk); #1;
    ready_mode = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready) && n < 10);
    chk("bp_first_pop_seen", int'(out_valid && out_ready), 1);
    chk("bp_no_same_cycle_credit", int'(in_ready), 0);
    @(negedge clk);
    chk("bp_credit_next_cycle", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    step(12);
    chk("bp_accepted_5", n_issued - base, 5);
    chk("bp_drained", exp_q.size(), 0);

    // Streaming
    strict_lat = 1'b1;
    base = n_issued;
    for (int i = 0; i < 20; i++) send(W'(i), W'(i + 1), W'(i));
    step(8);
    chk("stream_issued", n_issued - base, 20);
    chk("stream_drained", exp_q.size(), 0);

    // Bubbles with random out_ready
    strict_lat = 1'b0;
    ready_mode = 2;
    base = n_issued;
    for (int i = 0; i < 6; i++) begin
      if (pat[i]) send(W'($urandom), W'($urandom), W'($urandom));
      else        step(1);
    end
    ready_mode = 1;
    step(15);
    chk("bubble_issued", n_issued - base, 4);
    chk("bubble_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("bubble_idle", int'(idle), 1);
    @(posedge clk); #1;

    // Reset mid-flight
    strict_lat = 1'b1;
    for (int i = 0; i < 3; i++) send(W'(100 + i), W'(3), W'(1));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_flight_no_out", int'(seen), 0);
    chk("rst_flight_idle", int'(idle), 1);
    @(posedge clk); #1;
    send(16'd1234, 16'd5, 16'd7);
    wait_out("rst_after_p", 1234 * 5 + 7);
    step(4);

    chk("final_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("final_idle", int'(idle), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
